// File: rtl/alu_pkg.sv
// Shared adder defaults, operation encoding and signed range helper.
// Latency: none (package only).
// Backpressure: not applicable.
package alu_pkg;

    localparam int DEFAULT_WIDTH = 64;
    localparam int DEFAULT_SEGS  = 4;

    // Widest operand the limit helper can describe.
    localparam int LIM_MAX_W = 256;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    typedef struct packed {
        logic [LIM_MAX_W-1:0] max;
        logic [LIM_MAX_W-1:0] min;
    } lim_t;

    // Largest positive and most negative two's complement value of w bits,
    // zero-extended to LIM_MAX_W; callers keep the low w bits.
    function automatic lim_t signed_limits(input int unsigned w);
        lim_t r;
        r.min = LIM_MAX_W'(1) << (w - 1);
        r.max = r.min - LIM_MAX_W'(1);
        return r;
    endfunction

endpackage

// File: rtl/addsub_seg.sv
// One carry segment: ripple adder of SW bits with carry in/out.
// Latency: combinational.
// Backpressure: none; the enclosing pipeline stage decides when to capture.
module addsub_seg #(
    parameter int SW = 16
) (
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    input  logic          cin,
    output logic [SW-1:0] sum,
    output logic          cout,
    output logic          msb_cin
);

    logic [SW:0] carry;

    // Bit-by-bit carry chain; carry[i] is the carry into bit i.
    always_comb begin
        sum      = '0;
        carry    = '0;
        carry[0] = cin;
        for (int i = 0; i < SW; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    end

    assign cout    = carry[SW];
    // Carry into the top bit; XOR with cout gives signed overflow when this
    // segment holds the operand MSB.
    assign msb_cin = carry[SW-1];

endmodule

// File: rtl/pipe_addsub.sv
// Pipelined add/subtract, one carry segment per stage (optional saturation: PIPE_ADDSUB_SAT_EN).
// Latency: SEGS cycles from acceptance to out_valid; one beat per cycle.
// Backpressure: global stall, in_ready = !out_valid | out_ready; all stages hold when low.
module pipe_addsub
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int SEGS  = DEFAULT_SEGS   // WIDTH must be a multiple of SEGS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             out_ovf
);

    localparam int SW   = WIDTH / SEGS;
    localparam int LAST = SEGS - 1;

    op_e              op;
    logic [WIDTH-1:0] b_x;       // B after the subtract inversion
    logic             advance;   // whole pipeline moves one stage

    // Per-stage registers. Stage k holds sum bits [0 .. (k+1)*SW-1] plus the
    // operands, so later stages can pick up their segment from the skew copy.
    logic [SEGS-1:0]  vld_q, vld_d;
    logic [WIDTH-1:0] a_q   [SEGS];
    logic [WIDTH-1:0] a_d   [SEGS];
    logic [WIDTH-1:0] b_q   [SEGS];
    logic [WIDTH-1:0] b_d   [SEGS];
    logic [WIDTH-1:0] sum_q [SEGS];
    logic [WIDTH-1:0] sum_d [SEGS];
    logic [SEGS-1:0]  carry_q, carry_d;
    logic             ovf_q, ovf_d;

    // Segment adder hookup, one adder per stage.
    logic [SW-1:0]    seg_a    [SEGS];
    logic [SW-1:0]    seg_b    [SEGS];
    logic [SW-1:0]    seg_sum  [SEGS];
    logic             seg_cin  [SEGS];
    logic             seg_cout [SEGS];
    logic             seg_msbc [SEGS];

    assign op        = op_e'(in_sub);
    assign b_x       = (op == OP_SUB) ? ~in_b : in_b;
    assign out_valid = vld_q[LAST];
    assign in_ready  = !out_valid || out_ready;
    assign advance   = in_ready;

    // Feed each segment adder: stage 0 straight from the inputs (the
    // subtract's +1 enters as carry-in), later stages from the previous stage.
    always_comb begin
        for (int k = 0; k < SEGS; k++) begin
            seg_a[k]   = '0;
            seg_b[k]   = '0;
            seg_cin[k] = 1'b0;
        end
        seg_a[0]   = in_a[SW-1:0];
        seg_b[0]   = b_x[SW-1:0];
        seg_cin[0] = (op == OP_SUB);
        for (int k = 1; k < SEGS; k++) begin
            seg_a[k]   = a_q[k-1][k*SW +: SW];
            seg_b[k]   = b_q[k-1][k*SW +: SW];
            seg_cin[k] = carry_q[k-1];
        end
    end

    for (genvar k = 0; k < SEGS; k++) begin : g_seg
        addsub_seg #(
            .SW (SW)
        ) u_seg (
            .a       (seg_a[k]),
            .b       (seg_b[k]),
            .cin     (seg_cin[k]),
            .sum     (seg_sum[k]),
            .cout    (seg_cout[k]),
            .msb_cin (seg_msbc[k])
        );
    end

    // Next-state: hold everything on stall, otherwise shift every stage
    // (bubbles included) forward by one and merge in its new sum segment.
    always_comb begin
        vld_d   = vld_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        if (advance) begin
            vld_d[0]            = in_valid;
            a_d[0]              = in_a;
            b_d[0]              = b_x;
            sum_d[0]            = '0;
            sum_d[0][SW-1:0]    = seg_sum[0];
            carry_d[0]          = seg_cout[0];
            for (int k = 1; k < SEGS; k++) begin
                vld_d[k]              = vld_q[k-1];
                a_d[k]                = a_q[k-1];
                b_d[k]                = b_q[k-1];
                sum_d[k]              = sum_q[k-1];
                sum_d[k][k*SW +: SW]  = seg_sum[k];
                carry_d[k]            = seg_cout[k];
            end
            // Operand signs equal and result sign differs <=> carry into and
            // out of the MSB disagree.
            ovf_d = seg_cout[LAST] ^ seg_msbc[LAST];
        end
    end

    // Valid bits clear asynchronously so no in-flight beat survives reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    // Datapath registers need no reset; they are qualified by the valid bits.
    always_ff @(posedge clk) begin
        a_q     <= a_d;
        b_q     <= b_d;
        sum_q   <= sum_d;
        carry_q <= carry_d;
        ovf_q   <= ovf_d;
    end

    assign out_carry = carry_q[LAST];
    assign out_ovf   = ovf_q;

`ifdef PIPE_ADDSUB_SAT_EN
    localparam lim_t             LIM     = signed_limits(WIDTH);
    localparam logic [WIDTH-1:0] SAT_MAX = LIM.max[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SAT_MIN = LIM.min[WIDTH-1:0];

    // On overflow clamp toward the sign of A (which is the true result sign).
    always_comb begin
        out_sum = sum_q[LAST];
        if (ovf_q) begin
            out_sum = a_q[LAST][WIDTH-1] ? SAT_MIN : SAT_MAX;
        end
    end
`else
    assign out_sum = sum_q[LAST];
`endif

endmodule

// File: doc/pipe_addsub.md
PIPE_ADDSUB -- requirements
Module: pipe_addsub

Interface
REQ-001 Parameter WIDTH, default 64: operand/result width in bits.
REQ-002 Parameter SEGS, default 4: number of carry segments, equal to the number of pipeline stages; WIDTH % SEGS SHALL be 0; SEGS=1 is legal.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operand beat present.
REQ-006 in_ready  output  1  block accepts a beat this cycle.
REQ-007 in_a  input  WIDTH  operand A, two's complement.
REQ-008 in_b  input  WIDTH  operand B, two's complement.
REQ-009 in_sub  input  1  0 selects A+B; 1 selects A-B.
REQ-010 out_valid  output  1  result beat present.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 out_sum  output  WIDTH  result, low WIDTH bits.
REQ-013 out_carry  output  1  carry out of the MSB (for subtract: 1 = no borrow).
REQ-014 out_ovf  output  1  signed overflow.

Function
REQ-015 Subtract SHALL be computed as A + ~B + 1, with carry-in 1 injected into segment 0.
REQ-016 Stage k SHALL add bits [k*W/S +: W/S] using the carry registered by stage k-1; operand segments not yet consumed SHALL be carried forward in skew registers.
REQ-017 Latency SHALL be exactly SEGS cycles from an accepted input beat to out_valid when out_ready is held high.
REQ-018 Throughput SHALL be one beat per cycle with no bubbles while out_ready=1.
REQ-019 Global stall: in_ready = !out_valid | out_ready; when in_ready=0, every stage and valid bit SHALL hold.
REQ-020 A stage valid bit SHALL travel with its data; bubbles SHALL propagate and SHALL not be compressed.
REQ-021 out_ovf = (A[W-1] == B'[W-1]) & (sum[W-1] != A[W-1]), where B' is B after the subtract inversion.
REQ-022 out_sum, out_carry and out_ovf SHALL stay stable while out_valid=1 and out_ready=0.
REQ-023 Beats SHALL leave in acceptance order; none SHALL be dropped or duplicated.
REQ-024 Overflow edge cases: 0x7FFF..F + 1 gives ovf=1; 0x8000..0 - 1 gives ovf=1; 0 - 0x8000..0 gives ovf=1 and sum 0x8000..0.

Reset
REQ-025 When rst_n=0, all valid bits SHALL clear immediately: out_valid=0, and in_ready=1 once rst_n rises.
REQ-026 Data, carry and flag registers need not reset; outputs SHALL be ignored while out_valid=0.
REQ-027 Reset asserted mid-operation SHALL discard all in-flight beats; no beat SHALL emerge after release without a new input.

Configuration
REQ-028 Macro PIPE_ADDSUB_SAT_EN defined: on overflow, out_sum SHALL clamp to 0x7FF..F if A[W-1]=0, else to 0x800..0; out_ovf SHALL still report 1; out_carry SHALL be unchanged.
REQ-029 Macro PIPE_ADDSUB_SAT_EN undefined: out_sum SHALL wrap modulo 2^WIDTH; no saturation logic SHALL be present.

Structure
REQ-030 Shared package alu_pkg SHALL hold the default WIDTH and SEGS values, an op enum (OP_ADD=0, OP_SUB=1) and a function returning the signed max and min for a width.
REQ-031 Sub-module addsub_seg SHALL be a combinational ripple adder of one segment (a, b, cin -> sum, cout, msb carry-in for the overflow check), instantiated SEGS times.

Verification
REQ-032 W=64, S=4, out_ready=1: 5+3 -> sum 8, carry 0, ovf 0, out_valid exactly 4 cycles after acceptance.
REQ-033 Subtract with 3-5 -> sum 0xFFFF_FFFF_FFFF_FFFE, carry 0, ovf 0; 5-3 -> sum 2, carry 1.
REQ-034 Overflow: 0x7FFF_FFFF_FFFF_FFFF+1 -> ovf 1, sum 0x8000_0000_0000_0000; with SAT_EN, sum 0x7FFF_FFFF_FFFF_FFFF.
REQ-035 Back-to-back 16 random beats, out_ready toggled pseudo-randomly -> results in order matching a reference model; in_ready=0 exactly when out_valid=1 and out_ready=0; outputs stable while stalled.
REQ-036 Cross-segment carry: 0x0000_0000_FFFF_FFFF+1 -> 0x0000_0001_0000_0000; also 0xFFFF..F+1 -> sum 0, carry 1.
REQ-037 Assert rst_n low with 3 beats in flight -> out_valid=0 immediately; after release, no output until a new beat, which returns at latency 4.
